alu_issuer: RTL and testbench

Sequential front end that drives the combinational ALU (ports A, B, ALUOp in; C out) from a small internal register file. It accepts 16-bit instruction words over a valid/ready handshake, reads operands, drives the ALU for one cycle, writes the result back and reports it on a valid/ready response port. It sits between the instruction source and the ALU and is the only master of the ALU's input ports.

---
 rtl/alu_issuer.sv | 131 +++++++++++++
 tb/tb_alu_issuer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - sequential front end that issues register operands to a combinational ALU
module alu_issuer #(
    parameter int REGS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_C,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_rd,
    output logic [15:0] retire_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_LI  = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic [1:0]  r_state;
    logic [15:0] r_instr;
    logic [31:0] r_regs [0:7];
    logic [31:0] r_result;
    logic [2:0]  r_rd;
    logic [15:0] r_retire_cnt;

    logic [2:0]  w_op;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic [2:0]  w_rt;
    logic [9:0]  w_imm;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_is_alu;
    logic        w_is_shift;
    logic        w_wr_en;
    logic [31:0] w_exec_val;

    // r0 and addresses beyond REGS are not backed by storage: reads give 0, writes vanish.
    function automatic logic addr_ok(input logic [2:0] a);
        return (a != 3'd0) && (32'(a) < REGS);
    endfunction

    assign w_op  = r_instr[15:13];
    assign w_rd  = r_instr[12:10];
    assign w_rs  = r_instr[9:7];
    assign w_rt  = r_instr[6:4];
    assign w_imm = r_instr[9:0];

    assign w_rs_val   = addr_ok(w_rs) ? r_regs[w_rs] : 32'd0;
    assign w_rt_val   = addr_ok(w_rt) ? r_regs[w_rt] : 32'd0;
    assign w_is_alu   = (w_op != OP_LI) && (w_op != OP_NOP);
    assign w_is_shift = (w_op == OP_SRL) || (w_op == OP_SRA);
    assign w_wr_en    = (w_op != OP_NOP) && addr_ok(w_rd);

    always_comb begin
        alu_A  = 32'd0;
        alu_B  = 32'd0;
        alu_op = 3'd0;
        if (r_state == ST_EXEC && w_is_alu) begin
            alu_A  = w_rs_val;
            alu_B  = w_is_shift ? {27'd0, w_rt_val[4:0]} : w_rt_val;
            alu_op = w_op;
        end
    end

    always_comb begin
        w_exec_val = 32'd0;
        if (w_is_alu) begin
            w_exec_val = alu_C;
        end else if (w_op == OP_LI) begin
            w_exec_val = {{22{w_imm[9]}}, w_imm};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_instr      <= 16'd0;
            r_result     <= 32'd0;
            r_rd         <= 3'd0;
            r_retire_cnt <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_instr <= in_instr;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= w_exec_val;
                    r_rd     <= w_rd;
                    if (w_wr_en) begin
                        r_regs[w_rd] <= w_exec_val;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        r_retire_cnt <= r_retire_cnt + 16'd1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_RESP);
    assign out_data   = r_result;
    assign out_rd     = r_rd;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - directed plus randomized bench for alu_issuer against a reference model
module tb_alu_issuer;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;
    localparam logic [2:0] OP_NOP = 3'd7;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_op;
    logic [31:0] alu_C;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_rd;
    logic [15:0] retire_cnt;

    int n_pass;
    int n_total;
    int n_fail;

    logic [31:0] m_regs [0:7];
    logic [15:0] m_cnt;

    alu_issuer #(.REGS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_op     (alu_op),
        .alu_C      (alu_C),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Combinational ALU; shifts use the full alu_B so an unmasked amount shows up.
    always_comb begin
        alu_C = 32'd0;
        case (alu_op)
            3'd0: alu_C = alu_A + alu_B;
            3'd1: alu_C = alu_A - alu_B;
            3'd2: alu_C = alu_A & alu_B;
            3'd3: alu_C = alu_A | alu_B;
            3'd4: alu_C = alu_A >> alu_B;
            3'd5: alu_C = $signed(alu_A) >>> alu_B;
            default: alu_C = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 4'd0};
    endfunction

    function automatic logic [15:0] mk_li(input logic [2:0] rd, input logic [9:0] imm);
        return {3'b110, rd, imm};
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        return (a == 3'd0) ? 32'd0 : m_regs[a];
    endfunction

    function automatic logic [31:0] m_result(input logic [15:0] ins);
        logic [31:0] a;
        logic [31:0] b;
        int          imm;
        int          sh;
        a   = m_read(ins[9:7]);
        b   = m_read(ins[6:4]);
        sh  = int'(b % 32);
        imm = int'(ins[9:0]);
        if (imm >= 512) imm = imm - 1024;
        case (ins[15:13])
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a / (32'd1 << sh);
            3'd5: return (a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh));
            3'd6: return 32'(imm);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_alu_a(input logic [15:0] ins);
        return (ins[15:13] <= 3'd5) ? m_read(ins[9:7]) : 32'd0;
    endfunction

    function automatic logic [31:0] m_alu_b(input logic [15:0] ins);
        if (ins[15:13] <= 3'd3) return m_read(ins[6:4]);
        if (ins[15:13] <= 3'd5) return m_read(ins[6:4]) % 32;
        return 32'd0;
    endfunction

    function automatic logic [2:0] m_alu_op(input logic [15:0] ins);
        return (ins[15:13] <= 3'd5) ? ins[15:13] : 3'd0;
    endfunction

    task automatic m_commit(input logic [15:0] ins);
        logic [31:0] v;
        v = m_result(ins);
        if (ins[15:13] != OP_NOP && ins[12:10] != 3'd0) m_regs[ins[12:10]] = v;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_cnt = 16'd0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        m_clear();
    endtask

    // Issue one instruction from IDLE, check EXEC and RESP, hold out_ready low for `hold` cycles.
    task automatic run(input logic [15:0] ins, input int hold);
        logic [31:0] exp_res;
        check("idle_in_ready", in_ready, 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_instr  = ins;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_instr = 16'($urandom);
        check("exec_in_ready", in_ready, 0);
        check("exec_out_valid", out_valid, 0);
        check("exec_alu_op", alu_op, m_alu_op(ins));
        check("exec_alu_A", alu_A, m_alu_a(ins));
        check("exec_alu_B", alu_B, m_alu_b(ins));
        exp_res = m_result(ins);
        @(posedge clk); #1;
        m_commit(ins);
        check("resp_out_valid", out_valid, 1);
        check("resp_out_data", out_data, exp_res);
        check("resp_out_rd", out_rd, ins[12:10]);
        check("resp_alu_A_zero", alu_A, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, exp_res);
            check("bp_in_ready", in_ready, 0);
            check("bp_retire_cnt", retire_cnt, m_cnt);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        m_cnt++;
        check("ret_out_valid", out_valid, 0);
        check("ret_in_ready", in_ready, 1);
        check("ret_retire_cnt", retire_cnt, m_cnt);
    endtask

    logic [15:0] prog [0:7];
    logic [31:0] q_data [$];
    logic [2:0]  q_rd [$];

    initial begin
        int k;
        int cyc;
        int last_acc;
        logic acc_now;
        logic [15:0] ins;

        clk       = 1'b0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'd0;
        out_ready = 1'b1;
        n_pass    = 0;
        n_total   = 0;
        n_fail    = 0;

        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_retire_cnt", retire_cnt, 0);
        check("rst_alu_A", alu_A, 0);
        check("rst_alu_B", alu_B, 0);
        check("rst_alu_op", alu_op, 0);

        run(mk_li(3'd1, 10'd5), 0);
        run(mk_li(3'd2, 10'h3FD), 0);
        run(mk(OP_ADD, 3'd3, 3'd1, 3'd2), 0);
        run(mk(OP_SUB, 3'd4, 3'd1, 3'd2), 0);
        check("plan_retire_4", retire_cnt, 16'd4);

        run(mk_li(3'd4, 10'd33), 0);
        run(mk(OP_SRL, 3'd5, 3'd2, 3'd4), 0);
        run(mk(OP_SRA, 3'd6, 3'd2, 3'd1), 0);
        run(mk(OP_AND, 3'd7, 3'd1, 3'd2), 0);
        run(mk(OP_OR,  3'd7, 3'd1, 3'd2), 0);
        run(mk(OP_ADD, 3'd0, 3'd1, 3'd1), 0);
        run(mk(OP_ADD, 3'd3, 3'd0, 3'd0), 0);

        run(mk(OP_SUB, 3'd6, 3'd2, 3'd1), 4);

        // Reset while the LI is in EXEC: its write must not land.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk_li(3'd1, 10'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_exec_state", in_ready, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_clear();
        check("rexec_out_valid", out_valid, 0);
        check("rexec_in_ready", in_ready, 1);
        check("rexec_retire_cnt", retire_cnt, 0);
        @(posedge clk); #1;
        check("rexec_out_valid2", out_valid, 0);
        run(mk(OP_ADD, 3'd2, 3'd1, 3'd0), 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk_li(3'd3, 10'd9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rresp_pre_valid", out_valid, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        m_clear();
        check("rresp_out_valid", out_valid, 0);
        check("rresp_retire_cnt", retire_cnt, 0);

        prog[0] = mk_li(3'd5, 10'd100);
        prog[1] = mk(OP_NOP, 3'd5, 3'd1, 3'd2);
        prog[2] = mk(OP_ADD, 3'd6, 3'd5, 3'd0);
        prog[3] = mk(OP_NOP, 3'd6, 3'd6, 3'd6);
        prog[4] = mk(OP_SUB, 3'd7, 3'd6, 3'd5);
        prog[5] = mk_li(3'd1, 10'h3FF);
        prog[6] = mk(OP_OR, 3'd2, 3'd1, 3'd5);
        prog[7] = mk(OP_NOP, 3'd0, 3'd0, 3'd0);
        k        = 0;
        cyc      = 0;
        last_acc = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = prog[0];
        while ((k < 8 || q_data.size() != 0) && cyc < 100) begin
            if (out_valid) begin
                if (q_data.size() == 0) begin
                    check("b2b_extra_resp", out_valid, 0);
                end else begin
                    check("b2b_out_data", out_data, q_data.pop_front());
                    check("b2b_out_rd", out_rd, q_rd.pop_front());
                end
            end
            acc_now = in_ready && in_valid;
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 3);
                last_acc = cyc;
                q_data.push_back(m_result(prog[k]));
                q_rd.push_back(prog[k][12:10]);
                m_commit(prog[k]);
                m_cnt++;
                k++;
                if (k < 8) begin
                    in_instr = prog[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_all_accepted", 32'(k), 8);
        check("b2b_drained", 32'(q_data.size()), 0);
        check("b2b_retire_cnt", retire_cnt, m_cnt);

        for (int i = 0; i < 60; i++) begin
            ins = mk(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom));
            if (ins[15:13] == 3'd6) ins[9:0] = 10'($urandom);
            run(ins, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
